// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, sequencer state type and operand-view helper
// for the multi-cycle MIPS fetch sequencer.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLT   = 6'b001010;
  localparam logic [5:0] OP_BGT   = 6'b001011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_RESOLVE = 3'd4,
    ST_HALT    = 3'd5,
    ST_ERROR   = 3'd6
  } state_t;

  // Word as the datapath should see it. BGT reuses the datapath SLT by
  // swapping rs and rt so the ALU computes rt < rs.
  function automatic logic [31:0] dp_view(input logic [31:0] w);
    if (w[31:26] == OP_BGT) begin
      return {w[31:26], w[20:16], w[25:21], w[15:0]};
    end
    return w;
  endfunction

endpackage

// File: rtl/mips_fetch_sequencer_if.sv
// Instruction-memory and datapath signals of the fetch sequencer.
//
// Handshake: the sequencer raises imem_req with imem_addr and holds both
// stable until imem_ack. A word transfers on a rising edge where imem_req
// and imem_ack are both high; imem_ack with imem_req low carries nothing.
// dp_exec is a single-cycle strobe; dp_result/dp_rs_data are consumed in
// the cycle after it.
interface mips_fetch_sequencer_if #(
  parameter int unsigned AW = 16
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic [31:0]   dp_instr;
  logic          dp_exec;
  logic [31:0]   dp_result;
  logic [31:0]   dp_rs_data;

  modport master (
    output imem_req, imem_addr, dp_instr, dp_exec,
    input  imem_ack, imem_rdata, dp_result, dp_rs_data
  );

  modport slave (
    input  imem_req, imem_addr, dp_instr, dp_exec,
    output imem_ack, imem_rdata, dp_result, dp_rs_data
  );
endinterface

// File: rtl/mips_next_pc.sv
// Combinational next-PC unit: branch decision from the datapath result,
// PC-relative branch target and JR register target, all modulo 2^AW.
module mips_next_pc
  import mips_pkg::*;
#(
  parameter int unsigned AW = 16
) (
  input  logic [5:0]    opcode,
  input  logic [5:0]    funct,
  input  logic [15:0]   imm16,
  input  logic [AW-1:0] pc,
  input  logic [31:0]   dp_result,
  input  logic [31:0]   dp_rs_data,
  output logic [AW-1:0] next_pc,
  output logic          taken
);

  logic [AW-1:0] seq_pc;
  logic [AW-1:0] br_tgt;
  logic [AW-1:0] jr_tgt;
  logic [31:0]   off32;
  logic          unused_rs_bits;

  assign seq_pc = pc + AW'(4);
  assign off32  = {{14{imm16[15]}}, imm16, 2'b00};
  assign br_tgt = seq_pc + off32[AW-1:0];
  // JR target is word aligned regardless of the low register bits.
  assign jr_tgt = {dp_rs_data[AW-1:2], 2'b00};
  assign unused_rs_bits = ^dp_rs_data;

  // Branch condition per opcode, then choose between sequential, branch and JR.
  always_comb begin
    taken   = 1'b0;
    next_pc = seq_pc;
    case (opcode)
      OP_BEQ:         taken = (dp_result == 32'd0);
      OP_BNE:         taken = (dp_result != 32'd0);
      OP_BLT, OP_BGT: taken = dp_result[0];
      default:        taken = 1'b0;
    endcase
    if (taken) begin
      next_pc = br_tgt;
    end
    if (opcode == OP_RTYPE && funct == FN_JR) begin
      next_pc = jr_tgt;
    end
  end

endmodule

// File: rtl/mips_fetch_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC, fetches over req/ack,
// strobes the datapath once per instruction and resolves the next PC.
module mips_fetch_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned   AW          = 16,
  parameter logic [AW-1:0] RESET_PC    = '0,
  parameter int unsigned   MEM_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  mips_fetch_sequencer_if.master bus,
  output logic [AW-1:0]          pc,
  output logic                   busy,
  output logic                   halted,
  output logic                   error,
  output logic [15:0]            retired,
  output state_t                 dbg_state
);

  localparam logic [7:0] TMO_LIM = 8'(MEM_TIMEOUT);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q;
  logic [31:0]   instr_q;
  logic [15:0]   retired_q;
  logic [7:0]    tmo_q;
  logic [7:0]    tmo_inc;
  logic [AW-1:0] npc;
  logic          br_taken;
  logic          is_halt;

  assign tmo_inc = tmo_q + 8'd1;
  assign is_halt = (instr_q[31:26] == OP_HALT);

  mips_next_pc #(.AW(AW)) u_next_pc (
    .opcode     (instr_q[31:26]),
    .funct      (instr_q[5:0]),
    .imm16      (instr_q[15:0]),
    .pc         (pc_q),
    .dp_result  (bus.dp_result),
    .dp_rs_data (bus.dp_rs_data),
    .next_pc    (npc),
    .taken      (br_taken)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ack has priority over the timeout in the last cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HALT, ST_ERROR: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.imem_ack)            state_d = ST_DECODE;
        else if (tmo_inc == TMO_LIM) state_d = ST_ERROR;
      end
      ST_DECODE:  state_d = is_halt ? ST_HALT : ST_EXEC;
      ST_EXEC:    state_d = ST_RESOLVE;
      ST_RESOLVE: state_d = ST_FETCH;
      default:    state_d = ST_IDLE;
    endcase
  end

  // PC, instruction latch, retire counter and fetch timeout counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
      tmo_q     <= '0;
    end else begin
      if (state_d == ST_FETCH && state_q != ST_FETCH) begin
        tmo_q <= '0;
      end else if (state_q == ST_FETCH && !bus.imem_ack) begin
        tmo_q <= tmo_inc;
      end
      if (state_q == ST_FETCH && bus.imem_ack) begin
        instr_q <= dp_view(bus.imem_rdata);
      end
      if (state_q == ST_DECODE && is_halt) begin
        pc_q <= pc_q + AW'(4);
      end
      if (state_q == ST_RESOLVE) begin
        pc_q <= npc;
        if (retired_q != 16'hFFFF) retired_q <= retired_q + 16'd1;
      end
    end
  end

  assign bus.imem_req  = (state_q == ST_FETCH);
  assign bus.imem_addr = pc_q;
  assign bus.dp_instr  = instr_q;
  assign bus.dp_exec   = (state_q == ST_EXEC);
  assign pc            = pc_q;
  assign busy          = !(state_q == ST_IDLE || state_q == ST_HALT || state_q == ST_ERROR);
  assign halted        = (state_q == ST_HALT);
  assign error         = (state_q == ST_ERROR);
  assign retired       = retired_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mips_fetch_sequencer.sv
// Self-checking bench for mips_fetch_sequencer: directed program prefix plus
// random instruction stream, instruction-level reference model, scoreboard.
module tb_mips_fetch_sequencer;
  import mips_pkg::*;

  localparam int N_ZW = 15;   // fetches served with zero wait states

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  mips_fetch_sequencer_if #(.AW(16)) bus ();
  logic [15:0] pc;
  logic        busy, halted, error;
  logic [15:0] retired;
  state_t      dbg_state;

  mips_fetch_sequencer #(.AW(16), .RESET_PC(16'h0000), .MEM_TIMEOUT(255)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .error     (error),
    .retired   (retired),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mem_q[$];        // instruction words in program order
  logic [31:0] exp_addr_q[$];   // expected fetch address per fetch
  logic [31:0] exp_instr_q[$];  // expected dp_instr per dp_exec
  logic [31:0] dp_res_q[$];
  logic [31:0] dp_rs_q[$];
  logic [31:0] exp_hpc_q[$];    // expected pc at each HALT
  logic [31:0] exp_hret_q[$];   // expected retired at each HALT
  logic [15:0] m_pc = 16'h0000;
  int          m_ret = 0;
  int          n_halt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_dp_instr(input logic [31:0] w);
    if (w[31:26] == 6'd11) return {w[31:26], w[20:16], w[25:21], w[15:0]};
    return w;
  endfunction

  function automatic logic [15:0] ref_next_pc(input logic [15:0] cur, input logic [31:0] w,
                                              input logic [31:0] res, input logic [31:0] rs);
    int   seq, tgt;
    logic cond;
    seq = (int'(cur) + 4) & 32'hFFFF;
    tgt = (int'(cur) + 4 + 4 * int'($signed(w[15:0]))) & 32'hFFFF;
    case (w[31:26])
      6'd4:        cond = (res == 32'd0);
      6'd5:        cond = (res != 32'd0);
      6'd10, 6'd11: cond = res[0];
      default:     cond = 1'b0;
    endcase
    if (w[31:26] == 6'd0 && w[5:0] == 6'd8) return rs[15:0] & 16'hFFFC;
    return cond ? 16'(tgt) : 16'(seq);
  endfunction

  // Issue one instruction: queue the word and every response it implies.
  task automatic add_step(input logic [31:0] w, input logic [31:0] res, input logic [31:0] rs);
    mem_q.push_back(w);
    exp_addr_q.push_back({16'h0, m_pc});
    if (w[31:26] == 6'h3F) begin
      m_pc = m_pc + 16'd4;
      n_halt++;
      exp_hpc_q.push_back({16'h0, m_pc});
      exp_hret_q.push_back(m_ret);
    end else begin
      exp_instr_q.push_back(ref_dp_instr(w));
      dp_res_q.push_back(res);
      dp_rs_q.push_back(rs);
      m_pc = ref_next_pc(m_pc, w, res, rs);
      if (m_ret < 65535) m_ret++;
    end
  endtask

  function automatic logic [31:0] jr_word();
    return {OP_RTYPE, 5'($urandom_range(0, 31)), 15'd0, FN_JR};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [25:0] f;
    int k;
    f = 26'($urandom);
    k = $urandom_range(0, 19);
    case (k)
      4, 5:    return {OP_RTYPE, f[25:11], 5'd0, 6'h20};
      6, 7:    return jr_word();
      8, 9:    return {OP_BEQ, f};
      10, 11:  return {OP_BNE, f};
      12, 13:  return {OP_BLT, f};
      14, 15:  return {OP_BGT, f};
      16:      return {OP_HALT, f};
      default: return {OP_ADDI, f};
    endcase
  endfunction

  // ---------------- instruction memory driver ----------------
  int served = 0;
  initial begin
    bit waiting;
    int wait_left;
    waiting = 0;
    wait_left = 0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.imem_ack) begin
        bus.imem_ack = 1'b0;
        waiting = 0;
      end else if (reset && bus.imem_req && mem_q.size() > 0) begin
        if (!waiting) begin
          waiting = 1;
          wait_left = (served < N_ZW) ? 0 : $urandom_range(0, 5);
        end
        if (wait_left == 0) begin
          bus.imem_ack = 1'b1;
          bus.imem_rdata = mem_q.pop_front();
          served++;
        end else begin
          wait_left--;
        end
      end
    end
  end

  // ---------------- datapath driver ----------------
  initial begin
    bus.dp_result = '0;
    bus.dp_rs_data = '0;
    forever begin
      @(negedge clk);
      if (bus.dp_exec && dp_res_q.size() > 0) begin
        bus.dp_result = dp_res_q.pop_front();
        bus.dp_rs_data = dp_rs_q.pop_front();
      end
    end
  end

  // ---------------- monitor ----------------
  int   cyc = 0;
  int   n_exec = 0;
  int   last_exec = 0;
  bit   prev_exec = 0;
  bit   req_active = 0;
  logic [15:0] held_addr = '0;
  always @(negedge clk) begin
    logic [31:0] e;
    cyc++;
    if (!reset) begin
      req_active = 0;
      prev_exec = 0;
    end else begin
      if (bus.imem_req) begin
        if (req_active) check("addr_stable", {16'h0, bus.imem_addr}, {16'h0, held_addr});
        else begin
          req_active = 1;
          held_addr = bus.imem_addr;
        end
        if (bus.imem_ack) begin
          req_active = 0;
          if (exp_addr_q.size() == 0) bound_fail("fetch_unexpected");
          else begin
            e = exp_addr_q.pop_front();
            check("fetch_addr", {16'h0, bus.imem_addr}, e);
          end
        end
      end else begin
        req_active = 0;
      end
      if (bus.dp_exec) begin
        check("exec_one_cycle", {31'd0, prev_exec}, 32'd0);
        check("exec_no_req", {31'd0, bus.imem_req}, 32'd0);
        if (exp_instr_q.size() == 0) bound_fail("exec_unexpected");
        else begin
          e = exp_instr_q.pop_front();
          check("dp_instr", bus.dp_instr, e);
        end
        if (n_exec == 1) check("exec_spacing", cyc - last_exec, 32'd4);
        n_exec++;
        last_exec = cyc;
      end
      prev_exec = bus.dp_exec;
    end
  end

  // ---------------- stimulus / sequencing ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halted(output bit ok);
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (halted) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'd0, bus.imem_req}, 32'd0);
    check({tag, "_exec"}, {31'd0, bus.dp_exec}, 32'd0);
    check({tag, "_instr"}, bus.dp_instr, 32'd0);
    check({tag, "_pc"}, {16'h0, pc}, 32'h0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_halted"}, {31'd0, halted}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_retired"}, {16'h0, retired}, 32'd0);
  endtask

  initial begin
    bit ok;
    int cnt;
    logic [31:0] e;
    reset = 1'b0;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("reset");
    end
    reset = 1'b1;

    // Directed prefix: straight-line, JR, wrap, branches at 0x0010, HALT at 0x0020.
    add_step({OP_ADDI, 5'd1, 5'd2, 16'h0005}, 32'd0, 32'd0);
    add_step({OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd0, 32'd0);
    add_step(jr_word(), 32'd0, 32'h0000_1237);
    add_step(jr_word(), 32'd0, 32'h0000_FFFF);
    add_step({OP_ADDI, 5'd4, 5'd4, 16'h0001}, 32'd0, 32'd0);
    add_step(jr_word(), 32'd0, 32'h0000_0010);
    add_step({OP_BEQ, 5'd1, 5'd2, 16'hFFFC}, 32'd0, 32'd0);
    add_step(jr_word(), 32'd0, 32'h0000_0010);
    add_step({OP_BNE, 5'd1, 5'd2, 16'hFFFC}, 32'd0, 32'd0);
    add_step(jr_word(), 32'd0, 32'h0000_0010);
    add_step({OP_BLT, 5'd1, 5'd2, 16'hFFFC}, 32'd1, 32'd0);
    add_step(jr_word(), 32'd0, 32'h0000_0010);
    add_step({OP_BGT, 5'd3, 5'd9, 16'hFFFC}, 32'd1, 32'd0);
    add_step(jr_word(), 32'd0, 32'h0000_0020);
    add_step({OP_HALT, 26'd0}, 32'd0, 32'd0);

    // Random stream, terminated by a HALT.
    for (int i = 0; i < 120; i++) begin
      add_step(rand_instr(), ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom, $urandom);
    end
    add_step({OP_HALT, 26'h155}, 32'd0, 32'd0);

    pulse_start();
    check("start_req", {31'd0, bus.imem_req}, 32'd1);
    check("start_addr", {16'h0, bus.imem_addr}, 32'h0);
    check("start_busy", {31'd0, busy}, 32'd1);

    for (int h = 0; h < n_halt; h++) begin
      wait_halted(ok);
      if (!ok) begin
        bound_fail("wait_halt");
        break;
      end
      e = exp_hpc_q.pop_front();
      check("halt_pc", {16'h0, pc}, e);
      e = exp_hret_q.pop_front();
      check("halt_retired", {16'h0, retired}, e);
      check("halt_busy", {31'd0, busy}, 32'd0);
      if (h == 0) begin
        check("first_halt_pc", {16'h0, pc}, 32'h0024);
        check("first_halt_retired", {16'h0, retired}, 32'd14);
      end
      if (h < n_halt - 1) pulse_start();
    end

    // Fetch timeout: no word available, the request must give up.
    pulse_start();
    cnt = 0;
    for (int i = 0; i < 1000 && !error; i++) begin
      if (bus.imem_req) cnt++;
      @(negedge clk);
    end
    check("tmo_error", {31'd0, error}, 32'd1);
    check("tmo_req_cycles", cnt, 32'd255);
    check("tmo_req_low", {31'd0, bus.imem_req}, 32'd0);
    check("tmo_busy", {31'd0, busy}, 32'd0);
    check("tmo_pc", {16'h0, pc}, {16'h0, m_pc});

    // Restart after error fetches from the same pc.
    add_step({OP_HALT, 26'd7}, 32'd0, 32'd0);
    pulse_start();
    wait_halted(ok);
    if (!ok) bound_fail("wait_halt_after_error");
    else begin
      e = exp_hpc_q.pop_front();
      check("err_restart_pc", {16'h0, pc}, e);
      e = exp_hret_q.pop_front();
      check("err_restart_retired", {16'h0, retired}, e);
    end

    // Reset asserted in EXEC.
    add_step({OP_ADDI, 5'd1, 5'd1, 16'h0001}, 32'd0, 32'd0);
    pulse_start();
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.dp_exec) begin
        ok = 1;
        break;
      end
    end
    if (!ok) bound_fail("wait_exec");
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("exec_reset");
    check("exec_reset_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b1;
    @(negedge clk);
    check("leftover_fetches", exp_addr_q.size(), 32'd0);
    check("leftover_execs", exp_instr_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
    $fatal(1);
  end

endmodule

// File: doc/mips_fetch_sequencer.md
Name: mips_fetch_sequencer

Overview:
Multi-cycle instruction sequencer for the non-pipelined MIPS datapath. It owns the program counter and fetches 32-bit instructions from instruction memory over a req/ack handshake. It presents each instruction to the datapath with a one-cycle execute strobe, then resolves BEQ/BNE/BLT/BGT/JR from the datapath result to select the next PC. It sits between the instruction memory and the datapath and replaces free-running PC increment with explicit sequencing.

Parameters:
AW, 16, PC / instruction address width in bits (byte address)
RESET_PC, 0, PC value loaded on reset
MEM_TIMEOUT, 255, max cycles FETCH waits for imem_ack before entering ERROR (8-bit counter)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  leave IDLE/HALT/ERROR and begin fetching at current pc
imem_req  out  1  instruction fetch request
imem_addr  out  AW  fetch address (= pc)
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
dp_instr  out  32  instruction driven to datapath, held stable from DECODE through RESOLVE
dp_exec  out  1  one-cycle datapath execute strobe
dp_result  in  32  datapath registered ALU result, valid in the cycle after dp_exec
dp_rs_data  in  32  datapath register-file read of rs (JR target)
pc  out  AW  current program counter
busy  out  1  high in any state other than IDLE, HALT, ERROR
halted  out  1  high in HALT
error  out  1  high in ERROR (fetch timeout)
retired  out  16  count of completed instructions, saturating

Behaviour:
- Reset (reset==0 at clk edge), regardless of current state: state=IDLE, pc=RESET_PC, imem_req=0, dp_exec=0, dp_instr=0, retired=0, timeout counter=0. halted, error and busy are 0 in IDLE.
- States: IDLE, FETCH, DECODE, EXEC, RESOLVE, HALT, ERROR.
- IDLE/HALT/ERROR --start--> FETCH. pc is unchanged, so start after HALT resumes at the instruction following HALT. The timeout counter clears on entry to FETCH.
- FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ack.
  - Ack in the same cycle as req completes the fetch: latch imem_rdata, go to DECODE.
  - imem_ack while imem_req==0 is ignored.
  - Counter increments each non-ack cycle. When the counter reaches MEM_TIMEOUT, go to ERROR and drop imem_req.
- DECODE: drive dp_instr from the latched word.
  - For BGT (opcode 001011), swap the rs and rt fields in dp_instr so the datapath SLT computes rt<rs.
  - Opcode 111111 is HALT: go to HALT without dp_exec. HALT does not count as retired; pc advances by 4.
  - All other opcodes go to EXEC.
- EXEC: dp_exec=1 for exactly one cycle, then RESOLVE.
- RESOLVE: sample dp_result and dp_rs_data, compute next pc, increment retired (saturate at 16'hFFFF), then go to FETCH. Next-pc rules:
  - default: pc+4
  - BEQ (000100): taken if dp_result==0
  - BNE (000101): taken if dp_result!=0
  - BLT (001010) and BGT (001011): taken if dp_result[0]==1
  - taken target = pc+4+(sign_ext(imm16)<<2), truncated to AW
  - JR (opcode 000000, funct 001000): pc = dp_rs_data[AW-1:0] with bits [1:0] forced to 0
- All pc arithmetic wraps modulo 2^AW, so pc=2^AW-4 plus 4 gives 0.
- Instruction latency with zero-wait memory (ack in the first FETCH cycle) is 4 cycles: FETCH, DECODE, EXEC, RESOLVE.
- start while busy is ignored.
- dp_exec is 0 in every state except EXEC.
- imem_req is 0 in every state except FETCH.

Decomposition:
- Shared package mips_pkg: opcode/funct constants (OP_RTYPE, OP_BEQ, OP_BNE, OP_BLT, OP_BGT, OP_ADDI, OP_HALT, FN_JR) and the state enum typedef.
- One natural sub-module, mips_next_pc: combinational next-PC/branch-decision unit taking the opcode, funct, imm16, pc, dp_result and dp_rs_data.

Test Plan:
- Reset/start: hold reset=0 for 3 cycles, release, pulse start → imem_req=1, imem_addr=0x0000, busy=1; every output equals its reset value while reset=0.
- Straight-line: ADDI then ADD, zero-wait ack → dp_exec pulses exactly 4 cycles apart, pc reads 0x0004 then 0x0008, retired=2.
- Branches at pc=0x0010 with imm=0xFFFC:
  - BEQ with dp_result=0 → pc=0x0004
  - BNE with dp_result=0 → pc=0x0014
  - BLT with dp_result=1 → taken
  - BGT → dp_instr rs/rt fields swapped relative to imem_rdata
- JR: dp_rs_data=0x0000_1237 → pc=0x1234. Wrap: pc=0xFFFC non-branch → next pc=0x0000.
- Memory stall/timeout:
  - ack after 5 cycles → imem_addr stable throughout, normal completion
  - no ack → error=1 after MEM_TIMEOUT cycles, imem_req=0; start → FETCH at the same pc
- HALT at pc=0x0020 → halted=1, busy=0, retired unchanged, pc=0x0024. Reset asserted during EXEC → IDLE next cycle, dp_exec=0, pc=RESET_PC.
